// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_I,
    ST_RD_J,
    ST_WR_I,
    ST_WR_J,
    ST_FIN
  } ksa_state_e;

  // Key byte 0 sits in the most significant byte of the packed key vector.
  function automatic int key_byte_msb(input int key_max, input int idx);
    return (key_max - idx) * BYTE_W - 1;
  endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Single-port S-box memory bus shared between the KSA engine and the array.
interface rc4_ksa_engine_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_wen;
  logic              mem_own;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wen,
    output mem_own,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wen,
    input  mem_own,
    output mem_rdata
  );

endinterface

// File: rtl/rc4_key_sel.sv
// Latched key storage plus the wrapping key-byte index k; presents key[k].
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int  KEY_MAX = 32,
  localparam int KL_W    = $clog2(KEY_MAX + 1),
  localparam int K_W     = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      advance,
  input  logic [KEY_MAX*BYTE_W-1:0] key_in,
  input  logic [KL_W-1:0]           key_len_in,
  output logic [BYTE_W-1:0]         key_byte
);

  logic [KEY_MAX*BYTE_W-1:0] key_q, key_d;
  logic [KL_W-1:0]           key_len_q, key_len_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [BYTE_W-1:0]         key_bytes [KEY_MAX];

  for (genvar gi = 0; gi < KEY_MAX; gi++) begin : g_byte
    localparam int MSB = key_byte_msb(KEY_MAX, gi);
    assign key_bytes[gi] = key_q[MSB -: BYTE_W];
  end

  assign key_byte = key_bytes[k_q];

  // Wrap by compare against key_len-1 so no modulo/divider is needed.
  always_comb begin
    key_d     = key_q;
    key_len_d = key_len_q;
    k_d       = k_q;
    if (load) begin
      key_d     = key_in;
      key_len_d = key_len_in;
      k_d       = '0;
    end else if (advance) begin
      k_d = (KL_W'(k_q) == key_len_q - KL_W'(1)) ? '0 : k_q + K_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      key_len_q <= '0;
      k_q       <= '0;
    end else begin
      key_q     <= key_d;
      key_len_q <= key_len_d;
      k_q       <= k_d;
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional S[i]=i fill, then 2**ADDR_W swap
// iterations over an external single-port memory with RD_LAT read latency.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int  ADDR_W  = 8,
  parameter int  KEY_MAX = 32,
  parameter int  RD_LAT  = 2,
  localparam int KL_W    = $clog2(KEY_MAX + 1),
  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      init_en,
  input  logic [KEY_MAX*BYTE_W-1:0] key,
  input  logic [KL_W-1:0]           key_len,
  rc4_ksa_engine_if.master          mem,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W-1:0]         out_j
);

  ksa_state_e        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] si_q, si_d;
  logic [ADDR_W-1:0] sj_q, sj_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wen_q, mem_wen_d;
  logic              own_q, own_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              start_ok;
  logic              lat_last;
  logic              i_last;
  logic              key_load;
  logic              key_adv;
  logic [BYTE_W-1:0] key_byte;

  assign start_ok = start && (key_len != '0) && (key_len <= KL_W'(KEY_MAX));
  assign lat_last = (lat_q == LAT_W'(RD_LAT - 1));
  assign i_last   = &i_q;

  rc4_key_sel #(
    .KEY_MAX (KEY_MAX)
  ) u_key_sel (
    .clk        (clk),
    .rst        (rst),
    .load       (key_load),
    .advance    (key_adv),
    .key_in     (key),
    .key_len_in (key_len),
    .key_byte   (key_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = init_en ? ST_FILL : ST_RD_I;
      ST_FILL: if (i_last) state_d = ST_RD_I;
      ST_RD_I: if (lat_last) state_d = ST_RD_J;
      ST_RD_J: if (lat_last) state_d = ST_WR_I;
      ST_WR_I: state_d = ST_WR_J;
      ST_WR_J: state_d = i_last ? ST_FIN : ST_RD_I;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Cancellation wins over any pending advance.
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    lat_d    = lat_q;
    key_load = 1'b0;
    key_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          i_d      = '0;
          j_d      = '0;
          lat_d    = '0;
          key_load = 1'b1;
        end
      end
      ST_FILL: i_d = i_q + ADDR_W'(1);
      ST_RD_I: begin
        if (lat_last) begin
          si_d  = mem.mem_rdata;
          j_d   = j_q + mem.mem_rdata + ADDR_W'(key_byte);
          lat_d = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_RD_J: begin
        if (lat_last) begin
          sj_d  = mem.mem_rdata;
          lat_d = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_WR_J: begin
        i_d     = i_q + ADDR_W'(1);
        key_adv = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered port
  // values line up with the cycle the FSM actually occupies that state.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wen_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_FILL: begin
        mem_addr_d  = i_d;
        mem_wdata_d = i_d;
        mem_wen_d   = 1'b1;
        busy_d      = 1'b1;
      end
      ST_RD_I: begin
        mem_addr_d = i_d;
        busy_d     = 1'b1;
      end
      ST_RD_J: begin
        mem_addr_d = j_d;
        busy_d     = 1'b1;
      end
      ST_WR_I: begin
        mem_addr_d  = i_d;
        mem_wdata_d = sj_d;
        mem_wen_d   = 1'b1;
        busy_d      = 1'b1;
      end
      ST_WR_J: begin
        mem_addr_d  = j_d;
        mem_wdata_d = si_d;
        mem_wen_d   = 1'b1;
        busy_d      = 1'b1;
      end
      ST_FIN:  done_d = 1'b1;
      default: ;
    endcase
    own_d = busy_d;
    err_d = (state_q == ST_IDLE) && start && !start_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      lat_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
      own_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
      own_q       <= own_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wen   = mem_wen_q;
  assign mem.mem_own   = own_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign out_j         = j_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: two configurations (RD_LAT=2/KEY_MAX=32 and
// RD_LAT=3/KEY_MAX=16), each with its own S-box memory model.
module tb_rc4_ksa_engine;

  localparam int NCFG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0]           rst_v, start_v, abort_v, init_v;
  logic [NCFG-1:0][255:0]    key_v;
  logic [NCFG-1:0][5:0]      key_len_v;
  logic [NCFG-1:0]           busy_v, done_v, err_v, wen_v, own_v;
  logic [NCFG-1:0][7:0]      addr_v, wdata_v, outj_v;
  logic [NCFG-1:0][1:0][7:0] ahist;
  logic [7:0]                mem_arr [NCFG][256];

  int busy_cnt [NCFG];
  int done_cnt [NCFG];
  int err_cnt  [NCFG];
  int wen_cnt  [NCFG];
  int own_cnt  [NCFG];

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_s [256];
  int         exp_j;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int KM  = (gi == 0) ? 32 : 16;
    localparam int RL  = (gi == 0) ? 2 : 3;
    localparam int KLW = $clog2(KM + 1);

    rc4_ksa_engine_if #(.ADDR_W(8)) ifc ();

    rc4_ksa_engine #(
      .ADDR_W  (8),
      .KEY_MAX (KM),
      .RD_LAT  (RL)
    ) u_dut (
      .clk     (clk),
      .rst     (rst_v[gi]),
      .start   (start_v[gi]),
      .abort   (abort_v[gi]),
      .init_en (init_v[gi]),
      .key     (key_v[gi][255 -: KM*8]),
      .key_len (key_len_v[gi][KLW-1:0]),
      .mem     (ifc),
      .busy    (busy_v[gi]),
      .done    (done_v[gi]),
      .err     (err_v[gi]),
      .out_j   (outj_v[gi])
    );

    assign addr_v[gi]  = ifc.mem_addr;
    assign wdata_v[gi] = ifc.mem_wdata;
    assign wen_v[gi]   = ifc.mem_wen;
    assign own_v[gi]   = ifc.mem_own;
    // Read data reflects the address presented RL-1 cycles earlier.
    assign ifc.mem_rdata = mem_arr[gi][ahist[gi][RL-2]];
  end

  // Memory models plus per-config activity counters.
  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      if (wen_v[c]) mem_arr[c][addr_v[c]] <= wdata_v[c];
      ahist[c][1]  <= ahist[c][0];
      ahist[c][0]  <= addr_v[c];
      busy_cnt[c]  <= busy_cnt[c] + (busy_v[c] ? 1 : 0);
      done_cnt[c]  <= done_cnt[c] + (done_v[c] ? 1 : 0);
      err_cnt[c]   <= err_cnt[c]  + (err_v[c]  ? 1 : 0);
      wen_cnt[c]   <= wen_cnt[c]  + (wen_v[c]  ? 1 : 0);
      own_cnt[c]   <= own_cnt[c]  + (own_v[c]  ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Software KSA on a snapshot of the current memory contents.
  task automatic model_ksa(input int c, input bit init, input int klen, input logic [255:0] kv);
    int         j;
    int         kmax;
    logic [7:0] t;
    logic [7:0] kb;
    kmax = (c == 0) ? 32 : 16;
    for (int i = 0; i < 256; i++) exp_s[i] = mem_arr[c][i];
    exp_j = 0;
    if (klen < 1 || klen > kmax) return;
    if (init) for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb       = kv[255 - 8*(i % klen) -: 8];
      j        = (j + int'(exp_s[i]) + int'(kb)) % 256;
      t        = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
    exp_j = j;
  endtask

  task automatic chk_idle(input int c, input string nm);
    chk({nm, "_busy"},  busy_v[c],  0);
    chk({nm, "_done"},  done_v[c],  0);
    chk({nm, "_err"},   err_v[c],   0);
    chk({nm, "_wen"},   wen_v[c],   0);
    chk({nm, "_own"},   own_v[c],   0);
    chk({nm, "_addr"},  addr_v[c],  0);
    chk({nm, "_wdata"}, wdata_v[c], 0);
    chk({nm, "_outj"},  outj_v[c],  0);
  endtask

  task automatic run_vec(input int c, input bit init, input int klen, input logic [255:0] kv,
                         input bit exp_err, input int exp_busy, input int restart_at,
                         input string nm);
    int b0, d0, e0, w0, o0, cyc, mism, exp_wen;
    bit got_done;
    model_ksa(c, init, klen, kv);
    b0 = busy_cnt[c];
    d0 = done_cnt[c];
    e0 = err_cnt[c];
    w0 = wen_cnt[c];
    o0 = own_cnt[c];
    @(negedge clk);
    init_v[c]    = init;
    key_v[c]     = kv;
    key_len_v[c] = 6'(klen);
    start_v[c]   = 1'b1;
    @(negedge clk);
    start_v[c] = 1'b0;
    cyc        = 0;
    got_done   = 1'b0;
    while (!exp_err && !got_done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      start_v[c] = (restart_at != 0 && cyc == restart_at);
      got_done   = done_v[c];
    end
    start_v[c] = 1'b0;
    repeat (3) @(negedge clk);
    exp_wen = exp_err ? 0 : ((init ? 256 : 0) + 512);
    chk({nm, "_busy_cycles"}, busy_cnt[c] - b0, exp_busy);
    chk({nm, "_own_cycles"},  own_cnt[c] - o0,  exp_busy);
    chk({nm, "_done_pulses"}, done_cnt[c] - d0, exp_err ? 0 : 1);
    chk({nm, "_err_pulses"},  err_cnt[c] - e0,  exp_err ? 1 : 0);
    chk({nm, "_writes"},      wen_cnt[c] - w0,  exp_wen);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[c][i] !== exp_s[i]) mism++;
    chk({nm, "_array_diffs"}, mism, 0);
    if (!exp_err) chk({nm, "_final_j"}, outj_v[c], exp_j);
    $display("vec %s cfg=%0d init=%0d klen=%0d busy_cycles=%0d writes=%0d done=%0d err=%0d",
             nm, c, init, klen, busy_cnt[c] - b0, wen_cnt[c] - w0,
             done_cnt[c] - d0, err_cnt[c] - e0);
  endtask

  typedef struct {
    int          cfg;
    bit          init;
    int          klen;
    logic [255:0] kv;
    bit          exp_err;
    int          exp_busy;
    int          restart_at;
    string       nm;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int b0, d0, w0, c, km, klen, ebusy;
    bit init;
    logic [255:0] kv;

    tbl[0] = '{0, 1'b1, 3,  {8'h00, 8'h02, 8'h49, 232'h0}, 1'b0, 1792, 0,  "ref_key"};
    tbl[1] = '{0, 1'b1, 0,  {8'h11, 248'h0},               1'b1, 0,    0,  "len_zero"};
    tbl[2] = '{0, 1'b1, 33, {8'h11, 248'h0},               1'b1, 0,    0,  "len_over"};
    tbl[3] = '{0, 1'b0, 1,  {8'h00, 248'h0},               1'b0, 1536, 0,  "no_init"};
    tbl[4] = '{1, 1'b1, 16, {128'h0123456789abcdeffedcba9876543210, 128'h0},
               1'b0, 2304, 0, "lat3_len16"};
    tbl[5] = '{1, 1'b0, 5,  {40'h1f2e3d4c5b, 216'h0},      1'b0, 2048, 0,  "lat3_len5"};
    tbl[6] = '{1, 1'b1, 17, {8'h22, 248'h0},               1'b1, 0,    0,  "lat3_over"};
    tbl[7] = '{0, 1'b1, 32, {256{1'b1}},                   1'b0, 1792, 0,  "len_max"};
    tbl[8] = '{0, 1'b1, 3,  {8'h00, 8'h02, 8'h49, 232'h0}, 1'b0, 1792, 10, "restart"};

    rst_v     = '1;
    start_v   = '0;
    abort_v   = '0;
    init_v    = '0;
    key_v     = '0;
    key_len_v = '0;
    repeat (3) @(negedge clk);
    rst_v = '0;
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");

    for (int v = 0; v < 9; v++) begin
      run_vec(tbl[v].cfg, tbl[v].init, tbl[v].klen, tbl[v].kv, tbl[v].exp_err,
              tbl[v].exp_busy, tbl[v].restart_at, tbl[v].nm);
    end

    // Abort 100 cycles after start, then a clean full schedule.
    d0 = done_cnt[0];
    @(negedge clk);
    init_v[0]    = 1'b1;
    key_v[0]     = {8'h00, 8'h02, 8'h49, 232'h0};
    key_len_v[0] = 6'd3;
    start_v[0]   = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (99) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_busy", busy_v[0], 0);
    chk("abort_wen",  wen_v[0],  0);
    chk("abort_own",  own_v[0],  0);
    w0 = wen_cnt[0];
    repeat (5) @(negedge clk);
    chk("abort_no_done",   done_cnt[0] - d0, 0);
    chk("abort_no_writes", wen_cnt[0] - w0,  0);
    $display("vec abort cfg=0 busy=%0d done=%0d", busy_v[0], done_cnt[0] - d0);
    run_vec(0, 1'b1, 3, {8'h00, 8'h02, 8'h49, 232'h0}, 1'b0, 1792, 0, "post_abort");

    // Reset during the first RD_J: only the fill writes happened, then idle.
    d0 = done_cnt[0];
    w0 = wen_cnt[0];
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (258) @(posedge clk);
    @(negedge clk);
    chk("rstrdj_busy",   busy_v[0], 1);
    chk("rstrdj_writes", wen_cnt[0] - w0, 256);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk_idle(0, "rst_mid");
    rst_v[0] = 1'b0;
    w0 = wen_cnt[0];
    repeat (5) @(negedge clk);
    chk("rst_no_writes", wen_cnt[0] - w0, 0);
    chk("rst_no_done",   done_cnt[0] - d0, 0);
    $display("vec rst_mid cfg=0 busy=%0d writes_after=%0d", busy_v[0], wen_cnt[0] - w0);
    run_vec(0, 1'b1, 3, {8'h00, 8'h02, 8'h49, 232'h0}, 1'b0, 1792, 0, "post_rst");

    // Randomized keys and lengths against the software model.
    for (int r = 0; r < 6; r++) begin
      c    = r % 2;
      km   = (c == 0) ? 32 : 16;
      klen = $urandom_range(1, km);
      init = (r < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int w = 0; w < 8; w++) kv[w*32 +: 32] = $urandom();
      ebusy = (init ? 256 : 0) + 256 * ((c == 0) ? 6 : 8);
      run_vec(c, init, klen, kv, 1'b0, ebusy, 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
